// File: rtl/lockin_demodulator.sv
// Lock-in demodulator: multiplies the measured response by sin/cos references and integrates I/Q sums over a commanded length.
// Optional DEMOD_SETTLE_EN adds a settle period (samples discarded) between start and integration.
module lockin_demodulator #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 32,
   parameter int ACC_W  = 64
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     cmd_trig_in,
   input  logic [15:0]              cmd_addr_in,
   input  logic [15:0]              cmd_data1_in,
   input  logic [15:0]              cmd_data2_in,
   input  logic signed [DATA_W-1:0] sig_in,
   input  logic signed [DATA_W-1:0] sin_in,
   input  logic signed [DATA_W-1:0] cos_in,
   output logic signed [ACC_W-1:0]  i_out,
   output logic signed [ACC_W-1:0]  q_out,
   output logic                     busy_out,
   output logic                     done_out
);

   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DRAIN} state_t;

   state_t                   state_q;
   logic [LEN_W-1:0]         len_q, cnt_q;
   logic                     drain_q;
`ifdef DEMOD_SETTLE_EN
   logic [15:0]              settle_q, settle_cnt_q;
`endif
   logic signed [DATA_W-1:0] sig_q, sin_q, cos_q;
   logic                     v1_q;
   logic signed [PROD_W-1:0] prod_i_q, prod_q_q;
   logic                     v2_q;
   logic signed [ACC_W-1:0]  acc_i_q, acc_q_q, acc_i_d, acc_q_d;
   logic signed [ACC_W-1:0]  i_out_q, q_out_q;
   logic                     done_q;

   logic                     cmd_hit, do_len_wr, do_start, do_abort, cmd_override;
   logic [31:0]              cmd_word;

   always_comb begin
      cmd_hit      = cmd_trig_in && (cmd_addr_in[15:8] == 8'h42);
      do_len_wr    = cmd_hit && (cmd_addr_in[7:0] == 8'h00);
      // A zero-length start is a no-op in every state so a running job is never clobbered by it.
      do_start     = cmd_hit && (cmd_addr_in[7:0] == 8'h01) && (len_q != '0);
      do_abort     = cmd_hit && (cmd_addr_in[7:0] == 8'h03) && (state_q != S_IDLE);
      cmd_override = do_start || do_abort;
      cmd_word     = {cmd_data2_in, cmd_data1_in};
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
      if (v2_q) begin
         acc_i_d = acc_i_q + ACC_W'(prod_i_q);
         acc_q_d = acc_q_q + ACC_W'(prod_q_q);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; later assignments in the block take priority.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         drain_q  <= 1'b0;
`ifdef DEMOD_SETTLE_EN
         settle_q     <= '0;
         settle_cnt_q <= '0;
`endif
         // NOTE: pipeline data registers are reset too, keeping the whole block in a known state after rst_in.
         sig_q    <= '0;
         sin_q    <= '0;
         cos_q    <= '0;
         v1_q     <= 1'b0;
         prod_i_q <= '0;
         prod_q_q <= '0;
         v2_q     <= 1'b0;
         acc_i_q  <= '0;
         acc_q_q  <= '0;
         i_out_q  <= '0;
         q_out_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         sig_q    <= sig_in;
         sin_q    <= sin_in;
         cos_q    <= cos_in;
         v1_q     <= (state_q == S_RUN);
         prod_i_q <= PROD_W'(sig_q) * PROD_W'(sin_q);
         prod_q_q <= PROD_W'(sig_q) * PROD_W'(cos_q);
         v2_q     <= v1_q;
         acc_i_q  <= acc_i_d;
         acc_q_q  <= acc_q_d;

         if (do_len_wr) len_q <= cmd_word[LEN_W-1:0];
`ifdef DEMOD_SETTLE_EN
         if (cmd_hit && (cmd_addr_in[7:0] == 8'h02)) settle_q <= cmd_data1_in;
`endif

         case (state_q)
`ifdef DEMOD_SETTLE_EN
            S_SETTLE: begin
               if (settle_cnt_q == 16'd1) state_q <= S_RUN;
               else                       settle_cnt_q <= settle_cnt_q - 16'd1;
            end
`endif
            S_RUN: begin
               if (cnt_q == LEN_W'(1)) begin
                  state_q <= S_DRAIN;
                  drain_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - LEN_W'(1);
               end
            end
            S_DRAIN: begin
               if (!drain_q) begin
                  drain_q <= 1'b1;
               end else if (!cmd_override) begin
                  // Last product lands this cycle, so publish the post-add value.
                  state_q <= S_IDLE;
                  i_out_q <= acc_i_d;
                  q_out_q <= acc_q_d;
                  done_q  <= 1'b1;
               end
            end
            default: ;
         endcase

         if (do_start) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            cnt_q   <= len_q;
            drain_q <= 1'b0;
`ifdef DEMOD_SETTLE_EN
            settle_cnt_q <= settle_q;
            state_q      <= (settle_q != '0) ? S_SETTLE : S_RUN;
`else
            state_q <= S_RUN;
`endif
         end else if (do_abort) begin
            state_q <= S_IDLE;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
         end
      end
   end

   assign i_out    = i_out_q;
   assign q_out    = q_out_q;
   assign busy_out = (state_q != S_IDLE);
   assign done_out = done_q;

endmodule

// File: tb/tb_lockin_demodulator.sv
// Self-checking bench for lockin_demodulator: constant-sample vector table, hand-written restart/abort/reset
// sequences, and randomized runs checked against a plain-arithmetic sum model.
module tb_lockin_demodulator;

   localparam int DATA_W = 16;
   localparam int LEN_W  = 32;
   localparam int ACC_W  = 64;

`ifdef DEMOD_SETTLE_EN
   localparam int SETTLE_CYC = 5;
`else
   localparam int SETTLE_CYC = 0;
`endif

   logic                     clk_in = 1'b0;
   logic                     rst_in = 1'b0;
   logic                     cmd_trig_in = 1'b0;
   logic [15:0]              cmd_addr_in = '0;
   logic [15:0]              cmd_data1_in = '0;
   logic [15:0]              cmd_data2_in = '0;
   logic signed [DATA_W-1:0] sig_in = '0;
   logic signed [DATA_W-1:0] sin_in = '0;
   logic signed [DATA_W-1:0] cos_in = '0;
   logic signed [ACC_W-1:0]  i_out, q_out;
   logic                     busy_out, done_out;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int len_model = 0;

   lockin_demodulator #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .cmd_trig_in(cmd_trig_in), .cmd_addr_in(cmd_addr_in),
      .cmd_data1_in(cmd_data1_in), .cmd_data2_in(cmd_data2_in), .sig_in(sig_in), .sin_in(sin_in),
      .cos_in(cos_in), .i_out(i_out), .q_out(q_out), .busy_out(busy_out), .done_out(done_out)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) if (done_out) done_cnt++;

   typedef struct {
      int      len;
      shortint sig;
      shortint sn;
      shortint cs;
      longint  ei;
      longint  eq;
   } vec_t;

   task automatic check(input string name, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic cmd(input logic [15:0] a, input logic [15:0] x1, input logic [15:0] x2);
      cmd_trig_in  = 1'b1;
      cmd_addr_in  = a;
      cmd_data1_in = x1;
      cmd_data2_in = x2;
      step();
      cmd_trig_in  = 1'b0;
   endtask

   task automatic junk();
      sig_in = 16'($urandom);
      sin_in = 16'($urandom);
      cos_in = 16'($urandom);
   endtask

   // Called right after the start strobe has been clocked in. Drives pre discarded cycles, then n summed
   // samples, then junk until done_out; lat counts clock edges from the strobe edge to done.
   task automatic run_window(input int n, input int pre, input bit rnd,
                             input shortint k_sig, input shortint k_sin, input shortint k_cos,
                             output longint si, output longint sq, output int lat, output bit busy_ok);
      si = 0;
      sq = 0;
      busy_ok = 1'b1;
      lat = 0;
      for (int p = 0; p < pre; p++) begin
         junk();
         if (!busy_out) busy_ok = 1'b0;
         step();
         lat++;
      end
      for (int k = 0; k < n; k++) begin
         if (rnd) junk();
         else begin
            sig_in = k_sig;
            sin_in = k_sin;
            cos_in = k_cos;
         end
         si += longint'(sig_in) * longint'(sin_in);
         sq += longint'(sig_in) * longint'(cos_in);
         if (!busy_out) busy_ok = 1'b0;
         if (rnd && $urandom_range(7, 0) == 0) begin
            int sel;
            sel = $urandom_range(4, 0);
            cmd_trig_in  = 1'b1;
            cmd_data1_in = 16'($urandom_range(40, 1));
            cmd_data2_in = 16'h0000;
            case (sel)
               0: cmd_addr_in = 16'h4301;
               1: cmd_addr_in = 16'h4103;
               2: cmd_addr_in = 16'h4204;
               3: cmd_addr_in = 16'h0201;
               default: begin
                  cmd_addr_in = 16'h4200;
                  len_model = int'(cmd_data1_in);
               end
            endcase
         end
         step();
         cmd_trig_in = 1'b0;
         lat++;
      end
      junk();
      while (!done_out && lat < n + pre + 12) begin
         if (!busy_out) busy_ok = 1'b0;
         step();
         lat++;
      end
   endtask

   task automatic finish_checks(input string name, input int lat, input int exp_lat,
                                input longint ei, input longint eq, input bit busy_ok);
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_busy_during"}, busy_ok, 1);
      check({name, "_done"}, done_out, 1);
      check({name, "_busy_at_done"}, busy_out, 0);
      check({name, "_i"}, i_out, ei);
      check({name, "_q"}, q_out, eq);
      step();
      check({name, "_done_pulse"}, done_out, 0);
   endtask

   initial begin
      vec_t   vecs[4];
      longint si, sq, hold_i, hold_q;
      int     lat, dc, n;
      bit     bok;

      vecs[0] = '{len: 4, sig: 100,    sn: 200,    cs: -50,    ei: 80000,       eq: -20000};
      vecs[1] = '{len: 1, sig: -32768, sn: -32768, cs: 32767,  ei: 1073741824,  eq: -1073709056};
      vecs[2] = '{len: 3, sig: 7,      sn: -3,     cs: 5,      ei: -63,         eq: 105};
      vecs[3] = '{len: 2, sig: 32767,  sn: 32767,  cs: -32768, ei: 2147352578,  eq: -2147418112};

      // Reset state
      repeat (3) step();
      check("rst_busy", busy_out, 0);
      check("rst_done", done_out, 0);
      check("rst_i", i_out, 0);
      check("rst_q", q_out, 0);
      rst_in = 1'b1;
      step();

      // Constant-sample table
      for (int v = 0; v < 4; v++) begin
         cmd(16'h4200, 16'(vecs[v].len), 16'h0000);
         junk();
         cmd(16'h4201, 16'h0000, 16'h0000);
         run_window(vecs[v].len, 0, 1'b0, vecs[v].sig, vecs[v].sn, vecs[v].cs, si, sq, lat, bok);
         finish_checks($sformatf("tab%0d", v), lat, vecs[v].len + 2, vecs[v].ei, vecs[v].eq, bok);
      end

      // Zero-length start is ignored
      cmd(16'h4200, 16'h0000, 16'h0000);
      dc = done_cnt;
      cmd(16'h4201, 16'h0000, 16'h0000);
      bok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (busy_out) bok = 1'b1;
         step();
      end
      check("len0_busy_seen", bok, 0);
      check("len0_no_done", done_cnt - dc, 0);
      check("len0_i_hold", i_out, vecs[3].ei);
      check("len0_q_hold", q_out, vecs[3].eq);

      // Restart mid-run: only the second run completes
      sig_in = 16'sd1;
      sin_in = 16'sd1;
      cos_in = 16'sd0;
      cmd(16'h4200, 16'd1000, 16'h0000);
      dc = done_cnt;
      cmd(16'h4201, 16'h0000, 16'h0000);
      repeat (9) step();
      cmd(16'h4201, 16'h0000, 16'h0000);
      lat = 0;
      while (!done_out && lat < 1100) begin
         step();
         lat++;
      end
      check("restart_latency", lat, 1002);
      check("restart_no_early_done", done_cnt - dc, 0);
      check("restart_i", i_out, 1000);
      check("restart_q", q_out, 0);
      step();
      check("restart_single_done", done_cnt - dc, 1);

      // Abort mid-run keeps previous results
      cmd(16'h4200, 16'd100, 16'h0000);
      junk();
      dc = done_cnt;
      cmd(16'h4201, 16'h0000, 16'h0000);
      for (int k = 0; k < 49; k++) begin
         junk();
         step();
      end
      check("abort_busy_before", busy_out, 1);
      cmd(16'h4203, 16'h0000, 16'h0000);
      check("abort_busy_after", busy_out, 0);
      repeat (120) step();
      check("abort_no_done", done_cnt - dc, 0);
      check("abort_i_hold", i_out, 1000);
      check("abort_q_hold", q_out, 0);
      cmd(16'h4203, 16'h0000, 16'h0000);
      check("abort_idle_busy", busy_out, 0);
      check("abort_idle_i", i_out, 1000);

      // Settle register write (ignored unless the settle feature is built in)
      cmd(16'h4202, 16'd5, 16'h0000);
      cmd(16'h4200, 16'd4, 16'h0000);
      cmd(16'h4201, 16'h0000, 16'h0000);
      run_window(4, SETTLE_CYC, 1'b0, -16'sd32768, -16'sd32768, 16'sd0, si, sq, lat, bok);
      finish_checks("settle", lat, SETTLE_CYC + 4 + 2, 64'sd4294967296, 0, bok);
      cmd(16'h4202, 16'h0000, 16'h0000);
      len_model = 4;

      // Randomized runs against the sum model
      for (int r = 0; r < 20; r++) begin
         if (r == 0 || $urandom_range(1, 0) == 1) begin
            len_model = $urandom_range(40, 1);
            cmd(16'h4200, 16'(len_model), 16'h0000);
         end
         n = len_model;
         junk();
         cmd(16'h4201, 16'h0000, 16'h0000);
         run_window(n, 0, 1'b1, 16'sd0, 16'sd0, 16'sd0, si, sq, lat, bok);
         finish_checks($sformatf("rnd%0d", r), lat, n + 2, si, sq, bok);
      end

      // Asynchronous reset mid-run
      hold_i = i_out;
      cmd(16'h4200, 16'd50, 16'h0000);
      sig_in = 16'sd100;
      sin_in = 16'sd100;
      cos_in = 16'sd100;
      cmd(16'h4201, 16'h0000, 16'h0000);
      repeat (10) step();
      #2;
      rst_in = 1'b0;
      #1;
      check("arst_busy", busy_out, 0);
      check("arst_done", done_out, 0);
      check("arst_i", i_out, 0);
      check("arst_q", q_out, 0);
      check("arst_i_changed", (hold_i != 0) ? (i_out != hold_i) : 1, 1);
      repeat (3) step();
      rst_in = 1'b1;
      dc = done_cnt;
      repeat (70) step();
      check("arst_no_done", done_cnt - dc, 0);

      // Recovery after reset (length register was cleared)
      cmd(16'h4201, 16'h0000, 16'h0000);
      check("post_rst_len0_busy", busy_out, 0);
      cmd(16'h4200, 16'd4, 16'h0000);
      junk();
      cmd(16'h4201, 16'h0000, 16'h0000);
      hold_q = 0;
      run_window(4, 0, 1'b0, 16'sd100, 16'sd200, -16'sd50, si, sq, lat, bok);
      finish_checks("recover", lat, 6, 80000, -20000 + hold_q, bok);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
